time_syn_ctrl: RTL and testbench

//   Sequences one time-sync round per slot start. Sits beside the ctrl-port frame parser and the ctrl frame TX builder.

---
 rtl/time_syn_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_time_syn_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/time_syn_ctrl.sv
// time_syn_ctrl: runs one time-sync round per slot start.
// As initiator it sends local time t1 in a TS frame and waits for the peer's
// RETURN frame (t4). The one-way link delay is (t4-t1)/2. It then loads the
// STD time plus that delay plus a fixed compensation.
// As responder it answers a peer TS frame with a RETURN frame. That frame
// carries the local time at which the TS frame arrived.
// It also owns the free-running 64-bit local time counter.
// Optional feature macro: TIME_SYN_AVG_EN. When defined, o_link_delay becomes
// the running mean of the old and new delay. The first round after reset loads
// the raw delay.
module time_syn_ctrl #(
  parameter int P_TICK_NS = 4,
  parameter int P_COMP_NS = 16,
  parameter int P_TIMEOUT = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_syn_start,
  input  logic        i_recv_ts_valid,
  input  logic        i_recv_return_valid,
  input  logic        i_recv_std_valid,
  input  logic [63:0] i_recv_std_time,
  output logic        o_tx_req,
  output logic [1:0]  o_tx_type,
  output logic [63:0] o_tx_data,
  input  logic        i_tx_ack,
  output logic [63:0] o_local_time,
  output logic [63:0] o_link_delay,
  output logic        o_busy,
  output logic        o_sync_done,
  output logic        o_sync_err
);

  localparam int TW = $clog2(P_TIMEOUT + 1);

  localparam logic [1:0] TX_NONE = 2'b00;
  localparam logic [1:0] TX_TS   = 2'b01;
  localparam logic [1:0] TX_RET  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_TS,
    S_WAIT_RET,
    S_WAIT_STD,
    S_SEND_RET
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [63:0]   r_local_time;
  logic [63:0]   r_cap_time;    // t1 (initiator) or TS arrival time (responder)
  logic [63:0]   r_link_delay;
  logic [TW-1:0] r_timer;
  logic          r_sync_done;
  logic          r_sync_err;

  logic          w_cap;
  logic          w_delay_ld;
  logic          w_time_ld;
  logic          w_done;
  logic          w_err;
  logic          w_timeout;
  logic          w_in_wait_next;
  logic [63:0]   w_new_delay;
  logic [63:0]   w_delay_val;

  // The modulo-2^64 subtract keeps the delay correct across a counter wrap.
  assign w_new_delay = (r_local_time - r_cap_time) >> 1;
  assign w_timeout   = (r_timer == TW'(P_TIMEOUT - 1));

`ifdef TIME_SYN_AVG_EN
  logic        r_avg_valid;
  logic [64:0] w_delay_sum;

  // Use the 65-bit sum so the mean keeps the carry out of bit 63.
  assign w_delay_sum = {1'b0, r_link_delay} + {1'b0, w_new_delay};
  assign w_delay_val = r_avg_valid ? 64'(w_delay_sum >> 1) : w_new_delay;

  // Remember that a delay has been measured, so later rounds average.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_avg_valid <= 1'b0;
    end else if (w_delay_ld) begin
      r_avg_valid <= 1'b1;
    end
  end
`else
  assign w_delay_val = w_new_delay;
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic, TX request outputs and datapath strobes.
  always_comb begin
    w_state_next = r_state;
    w_cap        = 1'b0;
    w_delay_ld   = 1'b0;
    w_time_ld    = 1'b0;
    w_done       = 1'b0;
    w_err        = 1'b0;
    o_tx_req     = 1'b0;
    o_tx_type    = TX_NONE;
    o_tx_data    = 64'd0;
    case (r_state)
      S_IDLE: begin
        // Slot start has priority; a simultaneous peer TS is dropped.
        if (i_syn_start) begin
          w_state_next = S_SEND_TS;
          w_cap        = 1'b1;
        end else if (i_recv_ts_valid) begin
          w_state_next = S_SEND_RET;
          w_cap        = 1'b1;
        end
      end
      S_SEND_TS: begin
        o_tx_req  = 1'b1;
        o_tx_type = TX_TS;
        o_tx_data = r_cap_time;
        if (i_tx_ack) begin
          w_state_next = S_WAIT_RET;
        end
      end
      S_SEND_RET: begin
        o_tx_req  = 1'b1;
        o_tx_type = TX_RET;
        o_tx_data = r_cap_time;
        if (i_tx_ack) begin
          w_state_next = S_IDLE;
        end
      end
      S_WAIT_RET: begin
        // A receive pulse beats a timeout that expires in the same cycle.
        if (i_recv_return_valid) begin
          w_state_next = S_WAIT_STD;
          w_delay_ld   = 1'b1;
        end else if (w_timeout) begin
          w_state_next = S_IDLE;
          w_err        = 1'b1;
        end
      end
      S_WAIT_STD: begin
        if (i_recv_std_valid) begin
          w_state_next = S_IDLE;
          w_time_ld    = 1'b1;
          w_done       = 1'b1;
        end else if (w_timeout) begin
          w_state_next = S_IDLE;
          w_err        = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_in_wait_next = (w_state_next == S_WAIT_RET) || (w_state_next == S_WAIT_STD);

  // The wait timer restarts whenever a wait state is entered, and idles at 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_timer <= '0;
    end else if (w_in_wait_next && (w_state_next == r_state)) begin
      r_timer <= r_timer + 1'b1;
    end else begin
      r_timer <= '0;
    end
  end

  // Local time counter: it free-runs, and a std-time load replaces the increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_local_time <= 64'd0;
    end else if (w_time_ld) begin
      r_local_time <= i_recv_std_time + r_link_delay + 64'(P_COMP_NS);
    end else begin
      r_local_time <= r_local_time + 64'(P_TICK_NS);
    end
  end

  // Capture the local time of the start/TS cycle, and record the link delay.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cap_time   <= 64'd0;
      r_link_delay <= 64'd0;
    end else begin
      if (w_cap) begin
        r_cap_time <= r_local_time;
      end
      if (w_delay_ld) begin
        r_link_delay <= w_delay_val;
      end
    end
  end

  // Register the single-cycle done/error pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync_done <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_sync_done <= w_done;
      r_sync_err  <= w_err;
    end
  end

  assign o_local_time = r_local_time;
  assign o_link_delay = r_link_delay;
  assign o_busy       = (r_state != S_IDLE);
  assign o_sync_done  = r_sync_done;
  assign o_sync_err   = r_sync_err;

endmodule

// File: tb/tb_time_syn_ctrl.sv
// Directed testbench for time_syn_ctrl (P_TICK_NS=4, P_COMP_NS=16, P_TIMEOUT=1000).
module tb_time_syn_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        syn_start = 1'b0;
  logic        ts_valid = 1'b0;
  logic        ret_valid = 1'b0;
  logic        std_valid = 1'b0;
  logic [63:0] std_time = 64'd0;
  logic        tx_req;
  logic [1:0]  tx_type;
  logic [63:0] tx_data;
  logic        tx_ack = 1'b0;
  logic [63:0] local_time;
  logic [63:0] link_delay;
  logic        busy;
  logic        sync_done;
  logic        sync_err;

  int checks = 0;
  int errors = 0;

  time_syn_ctrl #(
    .P_TICK_NS(4),
    .P_COMP_NS(16),
    .P_TIMEOUT(1000)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_syn_start        (syn_start),
    .i_recv_ts_valid    (ts_valid),
    .i_recv_return_valid(ret_valid),
    .i_recv_std_valid   (std_valid),
    .i_recv_std_time    (std_time),
    .o_tx_req           (tx_req),
    .o_tx_type          (tx_type),
    .o_tx_data          (tx_data),
    .i_tx_ack           (tx_ack),
    .o_local_time       (local_time),
    .o_link_delay       (link_delay),
    .o_busy             (busy),
    .o_sync_done        (sync_done),
    .o_sync_err         (sync_err)
  );

  always #5 clk = ~clk;

  // Safety net in case the design never lets the sequence progress.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Initiator round: t1 is taken at the current cycle and t4 = t1 + 4*n.
  // The expected raw delay is therefore 2*n.
  task automatic do_round(input int n);
    syn_start = 1'b1; tick(); syn_start = 1'b0;
    tx_ack = 1'b1;    tick(); tx_ack = 1'b0;
    repeat (n - 2) tick();
    ret_valid = 1'b1; tick(); ret_valid = 1'b0;
  endtask

  task automatic send_std(input logic [63:0] v);
    std_time = v; std_valid = 1'b1; tick(); std_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (10) tick();
    checks++; if (local_time !== 64'd40) begin errors++; $display("FAIL reset_local: got %0d expected 40", local_time); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (tx_req !== 1'b0 || tx_type !== 2'b00) begin errors++; $display("FAIL reset_tx: got req %0b type %0d expected 0 0", tx_req, tx_type); end
    checks++; if (link_delay !== 64'd0) begin errors++; $display("FAIL reset_delay: got %0d expected 0", link_delay); end
  endtask

  task automatic test_sync_round();
    repeat (90) tick();                     // local = 400
    syn_start = 1'b1; tick(); syn_start = 1'b0;
    checks++; if (tx_req !== 1'b1 || tx_type !== 2'b01 || tx_data !== 64'd400) begin errors++; $display("FAIL ts_tx: got req %0b type %0d data %0d expected 1 1 400", tx_req, tx_type, tx_data); end
    tick();
    checks++; if (tx_req !== 1'b1 || tx_data !== 64'd400) begin errors++; $display("FAIL ts_hold: got req %0b data %0d expected 1 400", tx_req, tx_data); end
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;   // local = 412, WAIT_RET
    checks++; if (tx_req !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ts_ack: got req %0b busy %0b expected 0 1", tx_req, busy); end
    repeat (47) tick();                     // local = 600
    ret_valid = 1'b1; tick(); ret_valid = 1'b0;
    checks++; if (link_delay !== 64'd100) begin errors++; $display("FAIL round_delay: got %0d expected 100", link_delay); end
    send_std(64'h1000);
    checks++; if (local_time !== 64'd4212) begin errors++; $display("FAIL std_load: got %0d expected 4212", local_time); end
    checks++; if (sync_done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %0b expected 1", sync_done); end
    tick();
    checks++; if (sync_done !== 1'b0 || busy !== 1'b0 || local_time !== 64'd4216) begin errors++; $display("FAIL after_done: got done %0b busy %0b local %0d expected 0 0 4216", sync_done, busy, local_time); end
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    seen = 1'b0;
    n = 0;
    syn_start = 1'b1; tick(); syn_start = 1'b0;
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    for (int i = 1; i <= 1100; i++) begin
      tick();
      if (sync_err === 1'b1) begin
        seen = 1'b1;
        n = i;
        break;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL timeout_seen: got no err pulse expected one within 1100 cycles"); end
    checks++; if (n !== 1000) begin errors++; $display("FAIL timeout_cycles: got %0d expected 1000", n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %0b expected 0", busy); end
    checks++; if (link_delay !== 64'd100) begin errors++; $display("FAIL timeout_delay: got %0d expected 100", link_delay); end
    tick();
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL err_pulse_len: got %0b expected 0", sync_err); end
  endtask

  task automatic test_responder();
    do_reset();
    repeat (200) tick();                    // local = 800
    ts_valid = 1'b1; tick(); ts_valid = 1'b0;
    checks++; if (tx_req !== 1'b1 || tx_type !== 2'b10 || tx_data !== 64'd800) begin errors++; $display("FAIL ret_tx: got req %0b type %0d data %0d expected 1 2 800", tx_req, tx_type, tx_data); end
    repeat (3) tick();
    checks++; if (tx_req !== 1'b1 || tx_data !== 64'd800) begin errors++; $display("FAIL ret_hold: got req %0b data %0d expected 1 800", tx_req, tx_data); end
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    checks++; if (tx_req !== 1'b0 || tx_type !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL ret_ack: got req %0b type %0d busy %0b expected 0 0 0", tx_req, tx_type, busy); end
  endtask

  task automatic test_ignore();
    syn_start = 1'b1; ts_valid = 1'b1; tick(); syn_start = 1'b0; ts_valid = 1'b0;
    checks++; if (tx_type !== 2'b01) begin errors++; $display("FAIL start_priority: got type %0d expected 1", tx_type); end
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;   // WAIT_RET
    syn_start = 1'b1; ts_valid = 1'b1; std_valid = 1'b1; tick();
    syn_start = 1'b0; ts_valid = 1'b0; std_valid = 1'b0;
    checks++; if (busy !== 1'b1 || tx_req !== 1'b0) begin errors++; $display("FAIL ignore_wait: got busy %0b req %0b expected 1 0", busy, tx_req); end
    tick();
    checks++; if (sync_done !== 1'b0) begin errors++; $display("FAIL ignore_std: got done %0b expected 0", sync_done); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    do_round(50);                           // delay 100, now in WAIT_STD
    checks++; if (link_delay !== 64'd100 || busy !== 1'b1) begin errors++; $display("FAIL pre_reset: got delay %0d busy %0b expected 100 1", link_delay, busy); end
    rst = 1'b1;
    #1;
    checks++; if (local_time !== 64'd0 || link_delay !== 64'd0 || busy !== 1'b0 || tx_req !== 1'b0 || tx_data !== 64'd0) begin errors++; $display("FAIL async_reset: got local %0d delay %0d busy %0b req %0b data %0d expected all 0", local_time, link_delay, busy, tx_req, tx_data); end
    tick();
    checks++; if (sync_done !== 1'b0 || sync_err !== 1'b0) begin errors++; $display("FAIL reset_pulses: got done %0b err %0b expected 0 0", sync_done, sync_err); end
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    logic [63:0] exp_d;
`ifdef TIME_SYN_AVG_EN
    exp_d = 64'd52;                         // (4 + 100) >> 1
`else
    exp_d = 64'd100;
`endif
    do_reset();
    do_round(2);                            // t1 = 0, t4 = 8 -> delay 4
    checks++; if (link_delay !== 64'd4) begin errors++; $display("FAIL small_delay: got %0d expected 4", link_delay); end
    send_std(64'hFFFF_FFFF_FFFF_FFE4);      // + 4 + 16 = 2^64 - 8
    checks++; if (local_time !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL near_wrap_load: got %0h expected fffffffffffffff8", local_time); end
    syn_start = 1'b1; tick(); syn_start = 1'b0;
    checks++; if (tx_data !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL wrap_t1: got %0h expected fffffffffffffff8", tx_data); end
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    checks++; if (local_time !== 64'd0) begin errors++; $display("FAIL counter_wrap: got %0h expected 0", local_time); end
    repeat (48) tick();                     // local = 192
    ret_valid = 1'b1; tick(); ret_valid = 1'b0;
    checks++; if (link_delay !== exp_d) begin errors++; $display("FAIL wrap_delay: got %0d expected %0d", link_delay, exp_d); end
    send_std(64'd0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_d;
`ifdef TIME_SYN_AVG_EN
    exp_d = 64'd150;
`else
    exp_d = 64'd200;
`endif
    do_reset();
    do_round(50);
    checks++; if (link_delay !== 64'd100) begin errors++; $display("FAIL b2b_first: got %0d expected 100", link_delay); end
    send_std(64'd0);
    do_round(100);
    checks++; if (link_delay !== exp_d) begin errors++; $display("FAIL b2b_second: got %0d expected %0d", link_delay, exp_d); end
    send_std(64'd0);
    checks++; if (local_time !== exp_d + 64'd16) begin errors++; $display("FAIL b2b_load: got %0d expected %0d", local_time, exp_d + 64'd16); end
  endtask

  initial begin
    test_reset();
    test_sync_round();
    test_timeout();
    test_responder();
    test_ignore();
    test_mid_reset();
    test_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
